// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle for shift_unit_arbiter: two requesters in, one tagged result out.
interface shift_unit_arbiter_if #(
  parameter int DATA_LEN  = 32,
  parameter int SHAMT_LEN = 5
);
  logic [1:0]           i_req_valid;
  logic [1:0]           o_req_ready;
  logic [DATA_LEN-1:0]  i_value_0;
  logic [DATA_LEN-1:0]  i_value_1;
  logic [SHAMT_LEN-1:0] i_shamt_0;
  logic [SHAMT_LEN-1:0] i_shamt_1;
  logic [1:0]           i_op_0;
  logic [1:0]           i_op_1;
  logic                 o_resp_valid;
  logic                 i_resp_ready;
  logic                 o_resp_id;
  logic [DATA_LEN-1:0]  o_result;
  logic                 o_busy;

  modport master (
    output i_req_valid, i_value_0, i_value_1, i_shamt_0, i_shamt_1, i_op_0, i_op_1,
    output i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_id, o_result, o_busy
  );

  modport slave (
    input  i_req_valid, i_value_0, i_value_1, i_shamt_0, i_shamt_1, i_op_0, i_op_1,
    input  i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_id, o_result, o_busy
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbitrated iterative shifter (SLL/SRL/SRA, at most MAX_STEP bits per cycle).
// Define SHIFT_ROTATE_EN to make op 11 a rotate-left; otherwise op 11 is SLL.
module shift_unit_arbiter #(
  parameter int DATA_LEN  = 32,
  parameter int SHAMT_LEN = 5,
  parameter int MAX_STEP  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  shift_unit_arbiter_if.slave  bus
);
  // state  | meaning
  // IDLE   | arbitrating, ready may be asserted
  // SHIFT  | applying up to MAX_STEP positions per cycle
  // DONE   | result held until the consumer accepts it
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int STEP_W = SHAMT_LEN + 1;

  state_t               r_state, w_next;
  logic                 r_last_grant;
  logic                 r_id;
  logic [DATA_LEN-1:0]  r_work;
  logic [SHAMT_LEN-1:0] r_rem;
  logic [1:0]           r_op;
  logic                 r_sign;

  logic [1:0]           w_ready;
  logic                 w_grant_id;
  logic                 w_accept;
  logic [SHAMT_LEN-1:0] w_sel_shamt;
  logic [STEP_W-1:0]    w_step;
  logic [DATA_LEN-1:0]  w_shifted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_sel_shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if ({1'b0, r_rem} == w_step) w_next = S_DONE;
      S_DONE:  if (bus.i_resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant goes to the requester that did not win last time when both are valid.
  always_comb begin
    w_ready = 2'b00;
    if (r_state == S_IDLE && i_rst_n) begin
      case (bus.i_req_valid)
        2'b01:   w_ready = 2'b01;
        2'b10:   w_ready = 2'b10;
        2'b11:   w_ready = r_last_grant ? 2'b01 : 2'b10;
        default: w_ready = 2'b00;
      endcase
    end
  end

  assign w_grant_id  = w_ready[1];
  assign w_accept    = |(bus.i_req_valid & w_ready);
  assign w_sel_shamt = w_grant_id ? bus.i_shamt_1 : bus.i_shamt_0;

  assign bus.o_req_ready  = w_ready;
  assign bus.o_resp_valid = (r_state == S_DONE);
  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_resp_id    = r_id;
  assign bus.o_result     = r_work;

  always_comb begin
    w_step = ({1'b0, r_rem} > STEP_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : {1'b0, r_rem};
    case (r_op)
      2'b01:   w_shifted = r_work >> w_step;
      2'b10:   w_shifted = (r_work >> w_step) |
                           (r_sign ? ~({DATA_LEN{1'b1}} >> w_step) : '0);
`ifdef SHIFT_ROTATE_EN
      2'b11:   w_shifted = (r_work << w_step) | (r_work >> (DATA_LEN - int'(w_step)));
`endif
      default: w_shifted = r_work << w_step;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_work       <= '0;
      r_rem        <= '0;
      r_op         <= 2'b00;
      r_sign       <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_id;
      r_id         <= w_grant_id;
      r_work       <= w_grant_id ? bus.i_value_1 : bus.i_value_0;
      r_rem        <= w_sel_shamt;
      r_op         <= w_grant_id ? bus.i_op_1 : bus.i_op_0;
      r_sign       <= w_grant_id ? bus.i_value_1[DATA_LEN-1] : bus.i_value_0[DATA_LEN-1];
    end else if (r_state == S_SHIFT) begin
      r_work <= w_shifted;
      r_rem  <= SHAMT_LEN'({1'b0, r_rem} - w_step);
    end
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter; follows SHIFT_ROTATE_EN for op 11 expectations.
module tb_shift_unit_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;
  int m_last = 1;

  always #5 clk = ~clk;

  shift_unit_arbiter_if #(.DATA_LEN(32), .SHAMT_LEN(5)) bus ();

  shift_unit_arbiter #(.DATA_LEN(32), .SHAMT_LEN(5), .MAX_STEP(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int s, input logic [1:0] op);
    logic [63:0] d;
    case (op)
      2'd1: return v >> s;
      2'd2: begin
        d = {{32{v[31]}}, v};
        d = d >> s;
        return d[31:0];
      end
      2'd3: begin
`ifdef SHIFT_ROTATE_EN
        d = {v, v};
        d = d << s;
        return d[63:32];
`else
        return v << s;
`endif
      end
      default: return v << s;
    endcase
  endfunction

  function automatic int ref_lat(input int s);
    return 1 + (s + 3) / 4;
  endfunction

  function int ref_grant(input logic [1:0] m);
    if (m == 2'b01) return 0;
    if (m == 2'b10) return 1;
    return (m_last == 0) ? 1 : 0;
  endfunction

  task automatic set_req(input int id, input logic [31:0] v, input int s, input logic [1:0] op);
    if (id == 0) begin
      bus.i_value_0 = v; bus.i_shamt_0 = 5'(s); bus.i_op_0 = op;
    end else begin
      bus.i_value_1 = v; bus.i_shamt_1 = 5'(s); bus.i_op_1 = op;
    end
  endtask

  task automatic start_req(input logic [1:0] mask, input bit keep, output int acc, output bit to);
    int n;
    n = 0;
    bus.i_req_valid = mask;
    #1;
    while (bus.o_req_ready == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    to  = (bus.o_req_ready == 2'b00);
    acc = bus.o_req_ready[1] ? 1 : 0;
    @(negedge clk);
    if (!keep) bus.i_req_valid = 2'b00;
  endtask

  task automatic wait_resp(output int lat, output bit to);
    lat = 1;
    while (!bus.o_resp_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    to = !bus.o_resp_valid;
  endtask

  task automatic finish_resp;
    bus.i_resp_ready = 1'b1;
    @(negedge clk);
    bus.i_resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_req_valid = 2'b11;
    set_req(0, 32'h1234_5678, 3, 2'd0);
    set_req(1, 32'h8765_4321, 5, 2'd1);
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (bus.o_req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", bus.o_req_ready); end
    tests_run++; if (bus.o_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got=%b exp=0", bus.o_resp_valid); end
    tests_run++; if (bus.o_result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
    tests_run++; if (bus.o_resp_id !== 1'b0) begin tests_failed++; $display("FAIL reset_id got=%b exp=0", bus.o_resp_id); end
    tests_run++; if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    rst_n = 1'b1;
    m_last = 1;
    @(negedge clk);
  endtask

  task automatic test_sll_basic;
    int acc, lat; bit to;
    set_req(0, 32'h0000_0001, 2, 2'd0);
    start_req(2'b01, 1'b0, acc, to);
    tests_run++; if (to || acc !== 0) begin tests_failed++; $display("FAIL sll_grant got=%0d timeout=%0d exp=0", acc, to); end
    wait_resp(lat, to);
    tests_run++; if (to || lat !== 2) begin tests_failed++; $display("FAIL sll_latency got=%0d exp=2", lat); end
    tests_run++; if (bus.o_result !== 32'h0000_0004) begin tests_failed++; $display("FAIL sll_result got=%h exp=00000004", bus.o_result); end
    tests_run++; if (bus.o_resp_id !== 1'b0) begin tests_failed++; $display("FAIL sll_id got=%b exp=0", bus.o_resp_id); end
    finish_resp();
    m_last = 0;
  endtask

  task automatic test_sra31;
    int acc, lat; bit to;
    set_req(1, 32'h8000_0000, 31, 2'd2);
    start_req(2'b10, 1'b0, acc, to);
    tests_run++; if (to || acc !== 1) begin tests_failed++; $display("FAIL sra_grant got=%0d timeout=%0d exp=1", acc, to); end
    wait_resp(lat, to);
    tests_run++; if (to || lat !== 9) begin tests_failed++; $display("FAIL sra_latency got=%0d exp=9", lat); end
    tests_run++; if (bus.o_result !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sra_result got=%h exp=ffffffff", bus.o_result); end
    tests_run++; if (bus.o_resp_id !== 1'b1) begin tests_failed++; $display("FAIL sra_id got=%b exp=1", bus.o_resp_id); end
    finish_resp();
    m_last = 1;
  endtask

  task automatic test_contention;
    int acc, lat, exp; bit to;
    logic [31:0] vals [2];
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; m_last = 1;
    vals[0] = 32'hA5A5_0001; vals[1] = 32'h5A5A_0002;
    set_req(0, vals[0], 0, 2'd1);
    set_req(1, vals[1], 0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      exp = i % 2;
      start_req(2'b11, 1'b1, acc, to);
      tests_run++; if (to || acc !== exp) begin tests_failed++; $display("FAIL contention_grant[%0d] got=%0d exp=%0d", i, acc, exp); end
      wait_resp(lat, to);
      tests_run++; if (to || lat !== 1) begin tests_failed++; $display("FAIL contention_latency[%0d] got=%0d exp=1", i, lat); end
      tests_run++; if (bus.o_result !== vals[exp] || bus.o_resp_id !== exp[0]) begin tests_failed++; $display("FAIL contention_resp[%0d] got=%h/%b exp=%h/%0d", i, bus.o_result, bus.o_resp_id, vals[exp], exp); end
      bus.i_resp_ready = 1'b1;
      #1;
      tests_run++; if (bus.o_req_ready !== 2'b00) begin tests_failed++; $display("FAIL handshake_ready[%0d] got=%b exp=00", i, bus.o_req_ready); end
      @(negedge clk);
      bus.i_resp_ready = 1'b0;
      m_last = exp;
    end
    bus.i_req_valid = 2'b00;
  endtask

  task automatic test_backpressure;
    int acc, lat, exp; bit to;
    logic [31:0] v, er;
    v = $urandom;
    set_req(0, v, 7, 2'd1);
    set_req(1, ~v, 3, 2'd0);
    exp = ref_grant(2'b11);
    er = (exp == 0) ? ref_shift(v, 7, 2'd1) : ref_shift(~v, 3, 2'd0);
    start_req(2'b11, 1'b1, acc, to);
    tests_run++; if (to || acc !== exp) begin tests_failed++; $display("FAIL bp_grant got=%0d exp=%0d", acc, exp); end
    wait_resp(lat, to);
    tests_run++; if (to) begin tests_failed++; $display("FAIL bp_resp timeout got=no_valid exp=valid"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_resp_valid !== 1'b1 || bus.o_result !== er || bus.o_resp_id !== exp[0] ||
          bus.o_req_ready !== 2'b00 || bus.o_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h id=%b rdy=%b busy=%b exp v=1 r=%h id=%0d rdy=00 busy=1",
                 i, bus.o_resp_valid, bus.o_result, bus.o_resp_id, bus.o_req_ready, bus.o_busy, er, exp);
      end
    end
    finish_resp();
    bus.i_req_valid = 2'b00;
    m_last = exp;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int acc, lat; bit to;
    set_req(0, $urandom | 32'h8000_0000, 31, 2'd2);
    start_req(2'b01, 1'b0, acc, to);
    tests_run++; if (to || acc !== 0) begin tests_failed++; $display("FAIL rmid_grant got=%0d exp=0", acc); end
    @(negedge clk); @(negedge clk);
    tests_run++; if (bus.o_busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_busy_before got=%b exp=1", bus.o_busy); end
    rst_n = 1'b0;
    set_req(0, 32'h0000_00C3, 0, 2'd1);
    set_req(1, 32'h0000_003C, 0, 2'd1);
    bus.i_req_valid = 2'b11;
    #1;
    tests_run++; if (bus.o_resp_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_req_ready !== 2'b00) begin tests_failed++; $display("FAIL rmid_in_reset got v=%b busy=%b rdy=%b exp 0/0/00", bus.o_resp_valid, bus.o_busy, bus.o_req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    start_req(2'b11, 1'b0, acc, to);
    tests_run++; if (to || acc !== 0) begin tests_failed++; $display("FAIL rmid_post_grant got=%0d exp=0", acc); end
    wait_resp(lat, to);
    tests_run++; if (to || lat !== 1 || bus.o_result !== 32'h0000_00C3 || bus.o_resp_id !== 1'b0) begin tests_failed++; $display("FAIL rmid_post_resp got lat=%0d r=%h id=%b exp lat=1 r=000000c3 id=0", lat, bus.o_result, bus.o_resp_id); end
    finish_resp();
    m_last = 0;
  endtask

  task automatic test_rotate;
    int acc, lat; bit to;
    logic [31:0] er;
`ifdef SHIFT_ROTATE_EN
    er = 32'h0000_0018;
`else
    er = 32'h0000_0010;
`endif
    set_req(0, 32'h8000_0001, 4, 2'd3);
    start_req(2'b01, 1'b0, acc, to);
    wait_resp(lat, to);
    tests_run++; if (to || lat !== 2 || bus.o_result !== er) begin tests_failed++; $display("FAIL rotate got lat=%0d r=%h exp lat=2 r=%h", lat, bus.o_result, er); end
    finish_resp();
    m_last = 0;
  endtask

  task automatic test_random;
    int acc, lat, exp, hold; bit to;
    logic [1:0]  mask;
    logic [31:0] v [2];
    int          s [2];
    logic [1:0]  op [2];
    logic [31:0] er;
    for (int i = 0; i < 40; i++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        v[k] = $urandom; s[k] = $urandom_range(0, 31); op[k] = 2'($urandom_range(0, 3));
        set_req(k, v[k], s[k], op[k]);
      end
      exp = ref_grant(mask);
      er  = ref_shift(v[exp], s[exp], op[exp]);
      start_req(mask, 1'b0, acc, to);
      tests_run++; if (to || acc !== exp) begin tests_failed++; $display("FAIL rand_grant[%0d] got=%0d exp=%0d mask=%b", i, acc, exp, mask); end
      wait_resp(lat, to);
      tests_run++; if (to || lat !== ref_lat(s[exp])) begin tests_failed++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, ref_lat(s[exp])); end
      tests_run++; if (bus.o_result !== er || bus.o_resp_id !== exp[0]) begin tests_failed++; $display("FAIL rand_resp[%0d] got=%h/%b exp=%h/%0d op=%0d s=%0d", i, bus.o_result, bus.o_resp_id, er, exp, op[exp], s[exp]); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        tests_run++; if (bus.o_resp_valid !== 1'b1 || bus.o_result !== er) begin tests_failed++; $display("FAIL rand_hold[%0d] got v=%b r=%h exp v=1 r=%h", i, bus.o_resp_valid, bus.o_result, er); end
      end
      finish_resp();
      m_last = exp;
    end
  endtask

  initial begin
    bus.i_req_valid  = 2'b00;
    bus.i_resp_ready = 1'b0;
    set_req(0, 32'h0, 0, 2'd0);
    set_req(1, 32'h0, 0, 2'd0);
    test_reset();
    test_sll_basic();
    test_sra31();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_rotate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
